// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the picoMIPS program loader.
// The FSM state encoding and the byte-per-instruction helper live here.
package prog_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        DONE
    } state_t;

    function automatic int bytes_per_instr(input int isize);
        return isize / BYTE_W;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program-memory writer: assembles instruction words MSB-first from a byte
// stream and writes them to sequential addresses while holding the CPU in reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int n     = 8,
    parameter int Psize = 6,
    parameter int Isize = n + 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [Psize-1:0] wr_addr,
    output logic [Isize-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done
);

    localparam int BPI   = bytes_per_instr(Isize);
    localparam int IDX_W = (BPI > 1) ? $clog2(BPI) : 1;

    state_t           state, state_nx;
    logic [IDX_W-1:0] byte_idx;
    logic [Psize-1:0] addr;
    logic [Psize:0]   count;
    logic [Isize-1:0] word;
    logic [Isize-1:0] word_nx;
    logic             xfer;
    logic             last_byte;
    logic             last_instr;

    assign xfer      = in_valid && in_ready;
    assign word_nx   = {word[Isize-BYTE_W-1:0], in_data};
    assign last_byte = (byte_idx == IDX_W'(BPI - 1));
    // Extra bit so a count of 2^Psize still compares correctly against addr.
    assign last_instr = ({1'b0, addr} == (count - 1'b1));

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        cpu_hold = (state != IDLE);
        case (state)
            IDLE: begin
                if (load_start) state_nx = COUNT;
            end
            COUNT: begin
                in_ready = 1'b1;
                if (xfer) state_nx = DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                if (xfer && last_byte) state_nx = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                state_nx = last_instr ? DONE : DATA;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            addr     <= '0;
            count    <= '0;
            word     <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr     <= '0;
                        byte_idx <= '0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        if (in_data[Psize-1:0] == '0)
                            count <= {1'b1, {Psize{1'b0}}};
                        else
                            count <= {1'b0, in_data[Psize-1:0]};
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word <= word_nx;
                        // Latch the write port here so it holds between strobes.
                        if (last_byte) begin
                            byte_idx <= '0;
                            wr_addr  <= addr;
                            wr_data  <= word_nx;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!last_instr) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one task per scenario, inline comparisons
// against hand-computed write sequences.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [23:0] wr_data;
    logic        cpu_hold;
    logic        done;

    prog_loader #(.n(8), .Psize(6), .Isize(24)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Write/done log sampled on the falling edge.
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic [5:0]  wq_addr[$];
    logic [23:0] wq_data[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            last_wr_cyc <= cyc;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [7:0] tx[$];
    int         tx_gap[$];

    task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
        bit got;
        got   = 0;
        waits = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
            waits++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h: in_ready never rose within 40 cycles", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_all();
        int w;
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], tx_gap[i], w);
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0;
        in_valid = 1'b1; in_data = 8'h99;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, cpu_hold, done, in_ready} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b addr=%h data=%h hold=%b done=%b rdy=%b want all 0",
                     wr_en, wr_addr, wr_data, cpu_hold, done, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_consume got rdy=%b hold=%b want 0 0", in_ready, cpu_hold);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_basic(input bit gaps);
        int  base, dbase, w;
        bit  seen;
        logic [7:0] bytes[7] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        int  gp[7] = '{1, 2, 3, 1, 0, 2, 3};
        base = wq_addr.size(); dbase = done_cnt;
        start_load();
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++; $display("FAIL hold_after_start got %b want 1", cpu_hold);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            send_byte(bytes[i], gaps ? gp[i] : 0, w);
            // First byte of the second word is offered while the WRITE is in progress.
            if (i == 4) begin
                checks++;
                if (w !== 1) begin
                    errors++; $display("FAIL held_in_write waits got %0d want 1", w);
                end
            end
        end
        wait_done(seen);
        checks++;
        if (!seen || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL done_pulse seen=%b hold=%b want 1 1", seen, cpu_hold);
        end
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL after_done hold=%b done=%b want 0 0", cpu_hold, done);
        end
        checks++;
        if (wq_addr.size() - base != 2) begin
            errors++; $display("FAIL basic_nwrites got %0d want 2", wq_addr.size() - base);
        end else begin
            checks++;
            if (wq_addr[base] !== 6'd0 || wq_data[base] !== 24'h123456) begin
                errors++; $display("FAIL basic_w0 got %h:%h want 00:123456", wq_addr[base], wq_data[base]);
            end
            checks++;
            if (wq_addr[base+1] !== 6'd1 || wq_data[base+1] !== 24'hABCDEF) begin
                errors++; $display("FAIL basic_w1 got %h:%h want 01:abcdef", wq_addr[base+1], wq_data[base+1]);
            end
        end
        checks++;
        if (done_cnt - dbase != 1 || done_cyc != last_wr_cyc + 1) begin
            errors++; $display("FAIL done_timing cnt=%0d done_cyc=%0d last_wr=%0d want 1, last_wr+1",
                               done_cnt - dbase, done_cyc, last_wr_cyc);
        end
        checks++;
        if (wr_addr !== 6'd1 || wr_data !== 24'hABCDEF || wr_en !== 1'b0) begin
            errors++; $display("FAIL port_hold got en=%b %h:%h want 0 01:abcdef", wr_en, wr_addr, wr_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        int  base;
        bit  seen;
        base = wq_addr.size();
        tx.delete(); tx_gap.delete();
        tx.push_back(8'h00); tx_gap.push_back(0);
        for (int i = 0; i < 64; i++) begin
            tx.push_back(8'(i)); tx_gap.push_back(0);
            tx.push_back(8'(i) ^ 8'hC3); tx_gap.push_back(0);
            tx.push_back(8'h5A); tx_gap.push_back(0);
        end
        start_load();
        send_all();
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL full_done not seen");
        end
        @(negedge clk);
        checks++;
        if (wq_addr.size() - base != 64) begin
            errors++; $display("FAIL full_nwrites got %0d want 64", wq_addr.size() - base);
        end else begin
            for (int i = 0; i < 64; i++) begin
                logic [23:0] exp;
                exp = {8'(i), 8'(i) ^ 8'hC3, 8'h5A};
                checks++;
                if (wq_addr[base+i] !== 6'(i) || wq_data[base+i] !== exp) begin
                    errors++;
                    $display("FAIL full_w%0d got %h:%h want %h:%h", i, wq_addr[base+i], wq_data[base+i], 6'(i), exp);
                end
            end
        end
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++; $display("FAIL full_hold got %b want 0", cpu_hold);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_count_high_bits();
        int  base;
        bit  seen;
        base = wq_addr.size();
        tx = '{8'h41, 8'h11, 8'h22, 8'h33};
        tx_gap = '{0, 0, 0, 0};
        start_load();
        send_all();
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || wq_addr.size() - base != 1) begin
            errors++; $display("FAIL cnt41 seen=%b nwrites=%0d want 1 1", seen, wq_addr.size() - base);
        end else begin
            checks++;
            if (wq_addr[base] !== 6'd0 || wq_data[base] !== 24'h112233) begin
                errors++; $display("FAIL cnt41_w0 got %h:%h want 00:112233", wq_addr[base], wq_data[base]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int  base, dbase;
        bit  seen;
        base = wq_addr.size(); dbase = done_cnt;
        tx = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hAB};
        tx_gap = '{0, 0, 0, 0, 0};
        start_load();
        send_all();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || in_ready !== 1'b0 || wr_addr !== 6'd0) begin
            errors++; $display("FAIL midreset_state hold=%b done=%b en=%b rdy=%b addr=%h want 0s",
                               cpu_hold, done, wr_en, in_ready, wr_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq_addr.size() - base != 1 || done_cnt != dbase) begin
            errors++; $display("FAIL midreset_writes nwrites=%0d dones=%0d want 1 0",
                               wq_addr.size() - base, done_cnt - dbase);
        end else begin
            checks++;
            if (wq_addr[base] !== 6'd0 || wq_data[base] !== 24'h123456) begin
                errors++; $display("FAIL midreset_w0 got %h:%h want 00:123456", wq_addr[base], wq_data[base]);
            end
        end
        @(posedge clk); #1;
        base = wq_addr.size();
        tx = '{8'h01, 8'h77, 8'h88, 8'h99};
        tx_gap = '{0, 1, 0, 2};
        start_load();
        send_all();
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || wq_addr.size() - base != 1) begin
            errors++; $display("FAIL reload seen=%b nwrites=%0d want 1 1", seen, wq_addr.size() - base);
        end else begin
            checks++;
            if (wq_addr[base] !== 6'd0 || wq_data[base] !== 24'h778899) begin
                errors++; $display("FAIL reload_w0 got %h:%h want 00:778899", wq_addr[base], wq_data[base]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_in_data();
        int  base, w;
        bit  seen;
        base = wq_addr.size();
        start_load();
        send_byte(8'h02, 0, w);
        send_byte(8'h01, 0, w);
        send_byte(8'h02, 0, w);
        send_byte(8'h03, 0, w);
        send_byte(8'h04, 0, w);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        send_byte(8'h05, 0, w);
        send_byte(8'h06, 0, w);
        wait_done(seen);
        @(negedge clk);
        checks++;
        if (!seen || wq_addr.size() - base != 2) begin
            errors++; $display("FAIL start_in_data seen=%b nwrites=%0d want 1 2", seen, wq_addr.size() - base);
        end else begin
            checks++;
            if (wq_addr[base] !== 6'd0 || wq_data[base] !== 24'h010203 ||
                wq_addr[base+1] !== 6'd1 || wq_data[base+1] !== 24'h040506) begin
                errors++; $display("FAIL start_in_data_w got %h:%h %h:%h want 00:010203 01:040506",
                                   wq_addr[base], wq_data[base], wq_addr[base+1], wq_data[base+1]);
            end
        end
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++; $display("FAIL start_in_data_hold got %b want 0", cpu_hold);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_full();
        test_count_high_bits();
        test_reset_mid_load();
        test_start_in_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
